// File: rtl/cfg_pkg.sv
// rtl/cfg_pkg.sv - shared types and defaults for the configuration register bank
package cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ADDR  = 2'd1,
    ST_DATA  = 2'd2,
    ST_WRITE = 2'd3
  } ser_state_e;

  localparam int DEF_NUM_REGS = 4;
  localparam int DEF_REG_W    = 16;
  localparam int DEF_MUX_NUM  = 8;
  localparam int DEF_MUX_W    = 6;

endpackage

// File: rtl/cfg_ser_loader.sv
// rtl/cfg_ser_loader.sv - bit-serial frame loader: MSB-first address then data, one WRITE cycle
module cfg_ser_loader
  import cfg_pkg::*;
#(
  parameter int NUM_REGS = DEF_NUM_REGS,
  parameter int ADR_W    = $clog2(NUM_REGS),
  parameter int REG_W    = DEF_REG_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             ser_en_i,
  input  logic             ser_vld_i,
  input  logic             ser_dat_i,
  output logic             busy_o,
  output logic             start_o,
  output logic             wr_o,
  output logic             err_o,
  output logic [ADR_W-1:0] adr_o,
  output logic [REG_W-1:0] dat_o
);

  localparam int FR_W  = ADR_W + REG_W;
  localparam int CNT_W = $clog2(FR_W + 1);
  localparam logic [CNT_W-1:0] ADR_LAST = CNT_W'(ADR_W - 1);
  localparam logic [CNT_W-1:0] DAT_LAST = CNT_W'(FR_W - 1);
  localparam logic [ADR_W:0]   NUM_REGS_L = (ADR_W + 1)'(NUM_REGS);

  ser_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [FR_W-1:0]  sh_q, sh_d;
  logic             busy_q, busy_d;
  logic             adr_ok;

  // Address and data share one shift register; address ends up in the top bits.
  assign adr_o  = sh_q[FR_W-1 -: ADR_W];
  assign dat_o  = sh_q[REG_W-1:0];
  assign adr_ok = {1'b0, adr_o} < NUM_REGS_L;
  assign busy_o = busy_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      sh_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    start_o = 1'b0;
    wr_o    = 1'b0;
    err_o   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (ser_en_i) begin
          state_d = ST_ADDR;
          cnt_d   = '0;
          start_o = 1'b1;
        end
      end
      ST_ADDR, ST_DATA: begin
        if (!ser_en_i) begin
          state_d = ST_IDLE;
        end else if (ser_vld_i) begin
          sh_d  = {sh_q[FR_W-2:0], ser_dat_i};
          cnt_d = cnt_q + 1'b1;
          if (state_q == ST_ADDR && cnt_q == ADR_LAST) state_d = ST_DATA;
          if (cnt_q == DAT_LAST) state_d = ST_WRITE;
        end
      end
      ST_WRITE: begin
        wr_o    = adr_ok;
        err_o   = !adr_ok;
        cnt_d   = '0;
        state_d = ser_en_i ? ST_ADDR : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: rtl/config_regbank.sv
// rtl/config_regbank.sv - shadow/active configuration registers with serial loader, readback and status mux
module config_regbank
  import cfg_pkg::*;
#(
  parameter int NUM_REGS  = DEF_NUM_REGS,
  parameter int REG_W     = DEF_REG_W,
  parameter int ADR_W     = $clog2(NUM_REGS),
  parameter int MUX_NUM   = DEF_MUX_NUM,
  parameter int MUX_W     = DEF_MUX_W,
  parameter int MUX_ADR_W = $clog2(MUX_NUM)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      wr_i,
  input  logic [ADR_W-1:0]          wr_adr_i,
  input  logic [REG_W-1:0]          wr_dat_i,
  input  logic                      ser_en_i,
  input  logic                      ser_vld_i,
  input  logic                      ser_dat_i,
  input  logic                      commit_i,
  output logic [NUM_REGS*REG_W-1:0] reg_o,
  input  logic [ADR_W-1:0]          rd_adr_i,
  output logic [REG_W-1:0]          rd_dat_o,
  output logic                      ser_busy_o,
  output logic                      ser_err_o,
  input  logic [MUX_ADR_W-1:0]      mux_adr_i,
  input  logic [MUX_NUM*MUX_W-1:0]  mux_i,
  output logic [MUX_W-1:0]          mux_o
);

  localparam logic [ADR_W:0] NUM_REGS_L = (ADR_W + 1)'(NUM_REGS);

  logic [REG_W-1:0] shd_q [NUM_REGS];
  logic [REG_W-1:0] shd_d [NUM_REGS];
  logic [REG_W-1:0] act_q [NUM_REGS];
  logic [MUX_W-1:0] mux_ch [MUX_NUM];
  logic [REG_W-1:0] rd_q;
  logic [MUX_W-1:0] mux_q;
  logic             err_q, err_d;
  logic             par_ok, rd_ok, collide;
  logic             ld_start, ld_wr, ld_err;
  logic [ADR_W-1:0] ld_adr;
  logic [REG_W-1:0] ld_dat;

  cfg_ser_loader #(
    .NUM_REGS (NUM_REGS),
    .ADR_W    (ADR_W),
    .REG_W    (REG_W)
  ) u_loader (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .ser_en_i  (ser_en_i),
    .ser_vld_i (ser_vld_i),
    .ser_dat_i (ser_dat_i),
    .busy_o    (ser_busy_o),
    .start_o   (ld_start),
    .wr_o      (ld_wr),
    .err_o     (ld_err),
    .adr_o     (ld_adr),
    .dat_o     (ld_dat)
  );

  assign par_ok  = wr_i && ({1'b0, wr_adr_i} < NUM_REGS_L);
  assign rd_ok   = {1'b0, rd_adr_i} < NUM_REGS_L;
  assign collide = par_ok && ld_wr && (ld_adr == wr_adr_i);

  // Parallel write has priority, which also resolves same-address collisions.
  always_comb begin
    shd_d = shd_q;
    for (int k = 0; k < NUM_REGS; k++) begin
      if (par_ok && wr_adr_i == ADR_W'(k)) shd_d[k] = wr_dat_i;
      else if (ld_wr && ld_adr == ADR_W'(k)) shd_d[k] = ld_dat;
    end
  end

  always_comb begin
    err_d = err_q;
    if (ld_start) err_d = 1'b0;
    else if (ld_err || collide) err_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int k = 0; k < NUM_REGS; k++) begin
        shd_q[k] <= '0;
        act_q[k] <= '0;
      end
      rd_q  <= '0;
      mux_q <= '0;
      err_q <= 1'b0;
    end else begin
      shd_q <= shd_d;
      if (commit_i) act_q <= shd_q;
      rd_q  <= rd_ok ? shd_q[rd_adr_i] : '0;
      mux_q <= mux_ch[mux_adr_i];
      err_q <= err_d;
    end
  end

  for (genvar g = 0; g < MUX_NUM; g++) begin : g_mux
    assign mux_ch[g] = mux_i[g*MUX_W +: MUX_W];
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    assign reg_o[g*REG_W +: REG_W] = act_q[g];
  end

  assign rd_dat_o  = rd_q;
  assign mux_o     = mux_q;
  assign ser_err_o = err_q;

endmodule
